// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue between instruction memory and IF/ID
//
// Purpose: issues sequential fetch requests, buffers in-order responses with their PCs
// in a DEPTH-entry FIFO and hands them to IF/ID under valid/ready. A redirect flushes
// the queue and marks every in-flight fetch for discard.
//
// Optional feature macro: IFQ_BYPASS_EN (same-cycle response-to-dequeue bypass when the
// queue is empty and nothing is pending discard).
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   redirect, redirect_pc      flush and restart fetch at redirect_pc
//   imem_req_valid/addr/ready  fetch request channel
//   imem_resp_valid/data       in-order fetch responses
//   deq_valid/pc/instr/ready   head of queue towards IF/ID
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        deq_valid,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr,
    input  logic        deq_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic credit_ok, req_ok, req_fire, resp_take, resp_live;
    logic fifo_valid, fifo_wr, fifo_rd, bypass, deq_ok;

    // Buffered plus in-flight fetches never exceed DEPTH, so every response has a slot.
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);

    always_comb begin
        req_ok     = !redirect && credit_ok;
        req_fire   = req_ok && imem_req_ready;
        // A response with nothing in flight is a leftover from before reset; ignore it.
        resp_take  = imem_resp_valid && (inflight_q != '0);
        resp_live  = resp_take && (drop_q == '0) && !redirect;
        fifo_valid = (count_q != '0) && !redirect;
`ifdef IFQ_BYPASS_EN
        bypass     = resp_live && (count_q == '0);
`else
        bypass     = 1'b0;
`endif
        deq_ok     = fifo_valid || bypass;
        fifo_rd    = fifo_valid && deq_ready;
        // A bypassed response taken by the consumer is never written.
        fifo_wr    = resp_live && !(bypass && deq_ready);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        inflight_d = inflight_q;
        case ({req_fire, resp_take})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_d     = inflight_d;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_take && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (resp_live)
                resp_pc_d = resp_pc_q + 32'd4;
            if (fifo_wr)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (fifo_rd)
                rd_ptr_d = rd_ptr_q + PW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_resp_data;
        end
    end

    always_comb begin
        imem_req_valid = !rst && req_ok;
        imem_req_addr  = rst ? 32'h0 : fetch_pc_q;
        deq_valid      = !rst && deq_ok;
        deq_pc         = 32'h0;
        deq_instr      = 32'h0;
        if (!rst && deq_ok) begin
            deq_pc    = pc_mem_q[rd_ptr_q];
            deq_instr = instr_mem_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
            if (count_q == '0) begin
                deq_pc    = resp_pc_q;
                deq_instr = imem_resp_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue against a queue-based model
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_ready = 1'b0;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .deq_valid(deq_valid), .deq_pc(deq_pc),
        .deq_instr(deq_instr), .deq_ready(deq_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          live;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Model: outstanding fetches (oldest first) and buffered instructions.
    req_t        pend[$];
    ent_t        q[$];
    logic [31:0] m_fetch_pc;
    int          cyc;

    logic [31:0] deq_log[$];
    logic [31:0] acc_log[$];
    int          first_deq_cyc;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        q.delete();
        m_fetch_pc = 32'h0;
    endtask

    task automatic step(input bit rd, input logic [31:0] rpc, input bit rready,
                        input bit wresp, input bit dready);
        bit   resp_go, exp_req, exp_deq, byp;
        req_t r;
        @(negedge clk);
        resp_go = wresp && (pend.size() > 0) && (pend[0].cyc < cyc);
        redirect        = rd;
        redirect_pc     = rpc;
        imem_req_ready  = rready;
        imem_resp_valid = resp_go;
        imem_resp_data  = resp_go ? instr_of(pend[0].addr) : $urandom;
        deq_ready       = dready;
        #1;
        exp_req = !rd && (q.size() + pend.size() < DEPTH);
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = !rd && (q.size() == 0) && resp_go && pend[0].live;
`endif
        exp_deq = !rd && ((q.size() != 0) || byp);
        chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req});
        if (exp_req) chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("deq_valid", {31'h0, deq_valid}, {31'h0, exp_deq});
        if (exp_deq) begin
            if (q.size() != 0) begin
                chk("deq_pc", deq_pc, q[0].pc);
                chk("deq_instr", deq_instr, q[0].instr);
            end else begin
                chk("deq_pc_bypass", deq_pc, pend[0].addr);
                chk("deq_instr_bypass", deq_instr, instr_of(pend[0].addr));
            end
        end
        if (deq_valid && dready) begin
            deq_log.push_back(deq_pc);
            if (first_deq_cyc < 0) first_deq_cyc = cyc;
        end
        if (imem_req_valid && rready) acc_log.push_back(imem_req_addr);

        // Model update for the coming clock edge.
        if (resp_go) r = pend.pop_front();
        if (rd) begin
            q.delete();
            foreach (pend[i]) pend[i].live = 1'b0;
            m_fetch_pc = rpc;
        end else begin
            if (exp_deq && dready && q.size() != 0) void'(q.pop_front());
            if (resp_go && r.live && !(byp && dready))
                q.push_back('{pc: r.addr, instr: instr_of(r.addr)});
            if (exp_req && rready) begin
                pend.push_back('{addr: m_fetch_pc, cyc: cyc, live: 1'b1});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step(0, 32'h0, 0, 1, 1);
    endtask

    initial begin
        int          exp_first;
        logic [31:0] rpc;
        model_reset();
        cyc = 0;
        first_deq_cyc = -1;

        // Outputs held low during reset.
        @(negedge clk);
        #1;
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_deq_valid", {31'h0, deq_valid}, 32'h0);
        chk("rst_deq_pc", deq_pc, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming with 1-cycle responses.
        for (int i = 0; i < 8; i++) step(0, 32'h0, 1, 1, 1);
`ifdef IFQ_BYPASS_EN
        exp_first = 1;
`else
        exp_first = 2;
`endif
        chk("first_deq_cycle", first_deq_cyc, exp_first);
        if (deq_log.size() >= 4) begin
            chk("stream_pc0", deq_log[0], 32'h0);
            chk("stream_pc1", deq_log[1], 32'h4);
            chk("stream_pc2", deq_log[2], 32'h8);
            chk("stream_pc3", deq_log[3], 32'hC);
        end else chk("stream_count", deq_log.size(), 4);

        // Stalled consumer: credit caps requests at DEPTH.
        drain();
        acc_log.delete();
        for (int i = 0; i < 10; i++) step(0, 32'h0, 1, 1, 0);
        chk("stall_requests", acc_log.size(), DEPTH);
        for (int i = 0; i < 10; i++) step(0, 32'h0, 1, 1, 1);

        // Redirect with two fetches in flight.
        drain();
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        step(1, 32'h100, 1, 0, 1);
        deq_log.delete();
        acc_log.delete();
        for (int i = 0; i < 12; i++) step(0, 32'h0, 1, 1, 1);
        chk("redir_first_req", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD, 32'h100);
        chk("redir_first_deq", deq_log.size() > 0 ? deq_log[0] : 32'hDEAD, 32'h100);

        // Second redirect before the discards drain.
        drain();
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        step(1, 32'h180, 1, 0, 1);
        step(0, 32'h0, 1, 1, 1);
        step(1, 32'h200, 1, 1, 1);
        deq_log.delete();
        for (int i = 0; i < 12; i++) step(0, 32'h0, 1, 1, 1);
        chk("redir2_first_deq", deq_log.size() > 0 ? deq_log[0] : 32'hDEAD, 32'h200);

        // Randomized traffic with occasional redirects (including near address wrap).
        for (int i = 0; i < 3000; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                               : ($urandom & 32'hFFFF_FFFC);
            step(($urandom_range(0, 19) == 0), rpc, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            if (i == 1500) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
                chk("midrst_deq_valid", {31'h0, deq_valid}, 32'h0);
                model_reset();
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
